// File: rtl/fcc_pkg.sv
// Shared constants and helpers for the ADC front-end filter blocks.
// Holds the sample width, default over-voltage limits and trip count,
// plus the consecutive over-limit counter update used by each channel.
package fcc_pkg;

  localparam int          SAMPLE_W          = 12;
  localparam logic [11:0] VOUT_OV_LIMIT_DEF = 12'd3000;
  localparam logic [11:0] VFC_OV_LIMIT_DEF  = 12'd3000;
  localparam int          OV_COUNT_DEF      = 3;
  localparam int          OV_CNT_W          = 4;

  // Next value of a consecutive over-limit counter: clears on any in-range
  // sample, counts up on an over-limit one and parks at the trip count.
  function automatic logic [OV_CNT_W-1:0] ov_cnt_next(
    input logic [OV_CNT_W-1:0] cnt,
    input logic                over,
    input logic [OV_CNT_W-1:0] cnt_max
  );
    if (!over) begin
      return '0;
    end else if (cnt == cnt_max) begin
      return cnt;
    end else begin
      return cnt + 4'd1;
    end
  endfunction

endpackage

// File: rtl/adc_sample_filter_sample_avg.sv
// Purpose: single-channel moving average over a 2**AVG_LOG2 sample window.
// Latency: avg_o registered 1 clock after sample_valid_i.
// Backpressure: none; every strobe is accepted, one per cycle sustained.
// Ports: clk_i/rst_ni clock and async active-low reset; sample_valid_i
//   write strobe; ptr_i shared window slot to overwrite; sample_i raw code;
//   avg_o truncated window average, held between strobes.
module sample_avg
  import fcc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sample_valid_i,
  input  logic [AVG_LOG2-1:0] ptr_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] avg_o
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = SAMPLE_W + AVG_LOG2;

  logic [SAMPLE_W-1:0] win_q [N];
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;

  // The outgoing entry is always part of sum_q, so the running sum never
  // underflows and returns exactly to zero when the window is all zeros.
  assign sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(win_q[ptr_i]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
      sum_q <= '0;
      avg_o <= '0;
    end else if (sample_valid_i) begin
      win_q[ptr_i] <= sample_i;
      sum_q        <= sum_d;
      avg_o        <= sum_d[SUM_W-1:AVG_LOG2];
    end
  end

endmodule

// File: rtl/adc_sample_filter.sv
// Purpose: averages Vfc/Vout ADC samples and flags sustained over-voltage.
// Latency: 1 clock from sample_valid_i to valid_o, averages and fault bits.
// Backpressure: none; accepts one sample per cycle, never gates on fault.
// Ports: clk_i, rst_ni (async active-low); sample_valid_i strobe with
//   vfc_i/vout_i raw codes; fault_clear_i level clear; vfc_o/vout_o filtered
//   values with valid_o strobe; primed_o window full; fault_o {vfc, vout}.
module adc_sample_filter
  import fcc_pkg::*;
#(
  parameter int          AVG_LOG2      = 2,
  parameter logic [11:0] VOUT_OV_LIMIT = VOUT_OV_LIMIT_DEF,
  parameter logic [11:0] VFC_OV_LIMIT  = VFC_OV_LIMIT_DEF,
  parameter int          OV_COUNT      = OV_COUNT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] vfc_i,
  input  logic [SAMPLE_W-1:0] vout_i,
  input  logic                fault_clear_i,
  output logic [SAMPLE_W-1:0] vfc_o,
  output logic [SAMPLE_W-1:0] vout_o,
  output logic                valid_o,
  output logic                primed_o,
  output logic [1:0]          fault_o
);

  localparam int                   N         = 1 << AVG_LOG2;
  localparam int                   FILL_W    = AVG_LOG2 + 1;
  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(N);
  localparam logic [OV_CNT_W-1:0]  OV_MAX    = OV_CNT_W'(OV_COUNT);

  logic [AVG_LOG2-1:0] ptr_q;
  logic [FILL_W-1:0]   fill_q;
  logic                valid_q;
  logic [OV_CNT_W-1:0] cnt_vout_q, cnt_vfc_q;
  logic [OV_CNT_W-1:0] cnt_vout_d, cnt_vfc_d;
  logic [1:0]          fault_q;

  sample_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_vfc (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_valid_i (sample_valid_i),
    .ptr_i          (ptr_q),
    .sample_i       (vfc_i),
    .avg_o          (vfc_o)
  );

  sample_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_vout (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_valid_i (sample_valid_i),
    .ptr_i          (ptr_q),
    .sample_i       (vout_i),
    .avg_o          (vout_o)
  );

  // Detection works on raw codes; a sample equal to the limit is in range.
  assign cnt_vout_d = ov_cnt_next(cnt_vout_q, vout_i > VOUT_OV_LIMIT, OV_MAX);
  assign cnt_vfc_d  = ov_cnt_next(cnt_vfc_q,  vfc_i  > VFC_OV_LIMIT,  OV_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      fill_q     <= '0;
      valid_q    <= 1'b0;
      cnt_vout_q <= '0;
      cnt_vfc_q  <= '0;
      fault_q    <= '0;
    end else begin
      valid_q <= sample_valid_i;
      if (sample_valid_i) begin
        ptr_q <= ptr_q + AVG_LOG2'(1);
        if (fill_q != FILL_FULL) begin
          fill_q <= fill_q + FILL_W'(1);
        end
      end
      // Clear wins over a coincident sample: that sample is still averaged
      // above but does not advance either over-voltage counter.
      if (fault_clear_i) begin
        cnt_vout_q <= '0;
        cnt_vfc_q  <= '0;
        fault_q    <= '0;
      end else if (sample_valid_i) begin
        cnt_vout_q <= cnt_vout_d;
        cnt_vfc_q  <= cnt_vfc_d;
        if (cnt_vout_d == OV_MAX) fault_q[0] <= 1'b1;
        if (cnt_vfc_d  == OV_MAX) fault_q[1] <= 1'b1;
      end
    end
  end

  // fill_q reaches N on the same edge that registers the Nth average.
  assign primed_o = (fill_q == FILL_FULL);
  assign valid_o  = valid_q;
  assign fault_o  = fault_q;

endmodule

// File: tb/tb_adc_sample_filter.sv
`timescale 1ns/1ps
module tb_adc_sample_filter;

  localparam int          AVG_LOG2 = 2;
  localparam int          N        = 1 << AVG_LOG2;
  localparam int          OV_COUNT = 3;
  localparam int          VOUT_LIM = 3000;
  localparam int          VFC_LIM  = 3000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sample_valid_i = 1'b0;
  logic [11:0] vfc_i = '0;
  logic [11:0] vout_i = '0;
  logic        fault_clear_i = 1'b0;
  logic [11:0] vfc_o, vout_o;
  logic        valid_o, primed_o;
  logic [1:0]  fault_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   vfc_hist[$];
  int   vout_hist[$];
  int   n_acc;
  int   run_vout, run_vfc;
  int   exp_vfc, exp_vout;
  logic exp_valid, exp_primed;
  logic [1:0] exp_fault;

  adc_sample_filter #(
    .AVG_LOG2      (AVG_LOG2),
    .VOUT_OV_LIMIT (12'd3000),
    .VFC_OV_LIMIT  (12'd3000),
    .OV_COUNT      (OV_COUNT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_valid_i (sample_valid_i),
    .vfc_i          (vfc_i),
    .vout_i         (vout_i),
    .fault_clear_i  (fault_clear_i),
    .vfc_o          (vfc_o),
    .vout_o         (vout_o),
    .valid_o        (valid_o),
    .primed_o       (primed_o),
    .fault_o        (fault_o)
  );

  always #19 clk_i = ~clk_i;

  function automatic int window_avg(input int hist[$]);
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s / N;
  endfunction

  task automatic model_reset();
    vfc_hist.delete();
    vout_hist.delete();
    n_acc = 0; run_vout = 0; run_vfc = 0;
    exp_vfc = 0; exp_vout = 0;
    exp_valid = 1'b0; exp_primed = 1'b0; exp_fault = 2'b00;
  endtask

  // One clock: apply inputs on the falling edge, advance the model, and
  // return shortly after the rising edge so outputs can be sampled.
  task automatic step(input logic v, input int vfc, input int vout, input logic clr);
    @(negedge clk_i);
    sample_valid_i = v;
    vfc_i          = 12'(vfc);
    vout_i         = 12'(vout);
    fault_clear_i  = clr;
    exp_valid = v;
    if (clr) begin
      run_vout = 0; run_vfc = 0; exp_fault = 2'b00;
    end
    if (v) begin
      vfc_hist.push_back(vfc);
      vout_hist.push_back(vout);
      if (vfc_hist.size() > N) void'(vfc_hist.pop_front());
      if (vout_hist.size() > N) void'(vout_hist.pop_front());
      exp_vfc  = window_avg(vfc_hist);
      exp_vout = window_avg(vout_hist);
      n_acc++;
      exp_primed = (n_acc >= N);
      if (!clr) begin
        run_vout = (vout > VOUT_LIM) ? run_vout + 1 : 0;
        run_vfc  = (vfc  > VFC_LIM)  ? run_vfc + 1  : 0;
        if (run_vout >= OV_COUNT) exp_fault[0] = 1'b1;
        if (run_vfc  >= OV_COUNT) exp_fault[1] = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    fault_clear_i  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    sample_valid_i = 1'b0;
    fault_clear_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk_i); #1;
    checks++;
    if ({vfc_o, vout_o, valid_o, primed_o, fault_o} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state got vfc=%0d vout=%0d valid=%b primed=%b fault=%b want all 0",
               vfc_o, vout_o, valid_o, primed_o, fault_o);
    end
  endtask

  task automatic test_fill();
    int samples[9] = '{100, 200, 300, 400, 800, 0, 0, 0, 0};
    int want[9]    = '{25, 75, 150, 250, 425, 375, 300, 200, 0};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 0, samples[i], 1'b0);
      checks++;
      if (vout_o !== 12'(want[i]) || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL fill_avg[%0d] got vout=%0d valid=%b want vout=%0d valid=1",
                 i, vout_o, valid_o, want[i]);
      end
      checks++;
      if (primed_o !== (i >= 3)) begin
        errors++;
        $display("FAIL fill_primed[%0d] got %b want %b", i, primed_o, (i >= 3));
      end
    end
    step(1'b0, 0, 0, 1'b0);
    checks++;
    if (valid_o !== 1'b0 || vout_o !== 12'd0) begin
      errors++;
      $display("FAIL fill_idle got valid=%b vout=%0d want valid=0 vout=0", valid_o, vout_o);
    end
  endtask

  task automatic test_ov_vout();
    int samples[6] = '{3001, 3001, 2999, 3001, 3001, 3001};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 0, samples[i], 1'b0);
      checks++;
      if (fault_o !== {1'b0, (i == 5)}) begin
        errors++;
        $display("FAIL ov_vout[%0d] got fault=%b want %b", i, fault_o, {1'b0, (i == 5)});
      end
    end
    step(1'b0, 0, 0, 1'b1);
    checks++;
    if (fault_o !== 2'b00) begin
      errors++;
      $display("FAIL ov_clear_idle got fault=%b want 00", fault_o);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 3000, 3000, 1'b0);
    checks++;
    if (fault_o !== 2'b00) begin
      errors++;
      $display("FAIL ov_at_limit got fault=%b want 00", fault_o);
    end
  endtask

  task automatic test_ov_clear();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3500, 3500, 1'b0);
    checks++;
    if (fault_o !== 2'b11) begin
      errors++;
      $display("FAIL ovc_trip got fault=%b want 11", fault_o);
    end
    step(1'b1, 3500, 0, 1'b1);
    checks++;
    if (fault_o !== 2'b00 || vfc_o !== 12'd3500) begin
      errors++;
      $display("FAIL ovc_clear got fault=%b vfc=%0d want fault=00 vfc=3500", fault_o, vfc_o);
    end
    // The cleared sample must not have counted: two more stay clean.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3500, 0, 1'b0);
      checks++;
      if (fault_o !== {(i == 2), 1'b0}) begin
        errors++;
        $display("FAIL ovc_recount[%0d] got fault=%b want %b", i, fault_o, {(i == 2), 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1'b0);
      checks++;
      if (valid_o !== 1'b1 || vfc_o !== 12'(exp_vfc) || vout_o !== 12'(exp_vout)) begin
        errors++;
        $display("FAIL b2b[%0d] got valid=%b vfc=%0d vout=%0d want valid=1 vfc=%0d vout=%0d",
                 i, valid_o, vfc_o, vout_o, exp_vfc, exp_vout);
      end
    end
    step(1'b0, 0, 0, 1'b0);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got valid=%b want 0", valid_o);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    step(1'b1, 50, 100, 1'b0);
    step(1'b1, 60, 200, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({vfc_o, vout_o, valid_o, primed_o, fault_o} !== 28'd0) begin
      errors++;
      $display("FAIL mid_reset got vfc=%0d vout=%0d valid=%b primed=%b fault=%b want all 0",
               vfc_o, vout_o, valid_o, primed_o, fault_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 0, 400, 1'b0);
    checks++;
    if (vout_o !== 12'd100 || primed_o !== 1'b0 || vfc_o !== 12'd0) begin
      errors++;
      $display("FAIL post_reset got vout=%0d primed=%b vfc=%0d want vout=100 primed=0 vfc=0",
               vout_o, primed_o, vfc_o);
    end
  endtask

  task automatic test_random();
    int vfc, vout;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      vfc  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(2995, 3005)) : int'($urandom_range(0, 4095));
      vout = ($urandom_range(0, 1) == 0) ? int'($urandom_range(2995, 3005)) : int'($urandom_range(0, 4095));
      step(($urandom_range(0, 9) < 7), vfc, vout, ($urandom_range(0, 29) == 0));
      checks++;
      if (vfc_o !== 12'(exp_vfc) || vout_o !== 12'(exp_vout) || valid_o !== exp_valid ||
          primed_o !== exp_primed || fault_o !== exp_fault) begin
        errors++;
        $display("FAIL random[%0d] got vfc=%0d vout=%0d valid=%b primed=%b fault=%b want vfc=%0d vout=%0d valid=%b primed=%b fault=%b",
                 i, vfc_o, vout_o, valid_o, primed_o, fault_o,
                 exp_vfc, exp_vout, exp_valid, exp_primed, exp_fault);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_ov_vout();
    test_ov_clear();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_filter.md
ADC_SAMPLE_FILTER -- requirements
Module: adc_sample_filter

Interface
REQ-001 Parameter AVG_LOG2, default 2, log2 of the moving-average window depth N (legal values 1..4).
REQ-002 Parameter VOUT_OV_LIMIT, default 12'd3000, Vout over-voltage threshold in raw ADC code.
REQ-003 Parameter VFC_OV_LIMIT, default 12'd3000, Vfc over-voltage threshold in raw ADC code.
REQ-004 Parameter OV_COUNT, default 3, number of consecutive over-limit samples that trips a fault (legal values 1..15).
REQ-005 clk_i  input  1  sole clock, 27 MHz system clock.
REQ-006 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-007 sample_valid_i  input  1  one-cycle strobe, driven from the ADC FSM end-of-conversion; Vfc and Vout samples are valid in this cycle.
REQ-008 vfc_i  input  12  raw flying-cap voltage code.
REQ-009 vout_i  input  12  raw output voltage code.
REQ-010 fault_clear_i  input  1  level; clears both latched faults.
REQ-011 vfc_o  output  12  filtered Vfc, fed to the controller.
REQ-012 vout_o  output  12  filtered Vout, fed to the controller.
REQ-013 valid_o  output  1  one-cycle strobe marking new vfc_o/vout_o; used as the controller clock enable.
REQ-014 primed_o  output  1  high once N samples have been accepted since reset.
REQ-015 fault_o  output  2  sticky over-voltage flags: bit0 = Vout, bit1 = Vfc.

Function
REQ-016 Each channel SHALL hold an N-entry circular buffer, a shared write pointer, and an accumulator (12+AVG_LOG2 bits) equal to the sum of the buffer contents.
REQ-017 On sample_valid_i, each channel SHALL do all of the following in the same clock edge: set sum <= sum + new - buffer[ptr]; set buffer[ptr] <= new; set ptr <= ptr+1, wrapping modulo N.
REQ-018 vfc_o and vout_o SHALL equal the updated sum >> AVG_LOG2 (truncation), registered.
REQ-019 valid_o SHALL pulse exactly 1 cycle after sample_valid_i; latency is 1 clock.
REQ-020 Back-to-back strobes (one per cycle) SHALL each be accepted and SHALL each produce a valid_o pulse.
REQ-021 Before the window is full, the average SHALL include the reset-zero entries; it is NOT divided by the fill count.
REQ-022 A fill counter SHALL saturate at N; primed_o SHALL assert in the same cycle as the valid_o for the Nth accepted sample.
REQ-023 Over-voltage detection SHALL use raw inputs, not filtered values.
REQ-024 For each channel, a sample strictly greater than its limit SHALL increment a consecutive counter; any other sample SHALL clear that counter to 0.
REQ-025 When a channel's counter reaches OV_COUNT, the matching fault_o bit SHALL set, aligned with that sample's valid_o, and SHALL stay set until cleared.
REQ-026 A sample exactly equal to the limit SHALL NOT count toward a fault.
REQ-027 The counter SHALL saturate at OV_COUNT.
REQ-028 fault_clear_i SHALL clear both fault bits and both counters.
REQ-029 When fault_clear_i coincides with sample_valid_i, the clear SHALL take priority; that sample is ignored for over-voltage counting but is still averaged.
REQ-030 The filter SHALL NOT gate data on fault; shutdown is the responsibility of the downstream modulator.

Reset
REQ-031 On rst_ni low, all of the following SHALL clear to 0 asynchronously: buffers, accumulators, pointer, fill counter, over-voltage counters, vfc_o, vout_o, valid_o, primed_o, fault_o.
REQ-032 A reset asserted mid-window SHALL discard all history; refilling restarts from zero after release.

Structure
REQ-033 Package fcc_pkg SHALL hold the ADC sample width (12), the default over-voltage limits, and the default OV_COUNT.
REQ-034 One sub-module, sample_avg (circular buffer, accumulator and average for a single channel), SHALL be instantiated twice; over-voltage logic and primed logic stay in the top-level block.

Verification
REQ-035 With AVG_LOG2=2, Vout samples 100, 200, 300, 400 -> vout_o = 25, 75, 150, 250; primed_o rises with the 4th valid_o.
REQ-036 Continuing REQ-035 with sample 800 -> vout_o = 425; then four samples of 0 -> final vout_o = 0 (accumulator returns exactly to 0, no drift).
REQ-037 With OV_COUNT=3, Vout samples 3001, 3001, 2999, 3001, 3001, 3001 -> fault_o[0] stays 0 until the 6th valid_o, then reads 1; a run of 3000 values never trips.
REQ-038 With fault_o=2'b11, raise fault_clear_i together with a Vfc sample of 3500 -> fault_o = 0, the Vfc counter = 0, and vfc_o updates normally.
REQ-039 Strobe sample_valid_i on 4 consecutive cycles -> 4 consecutive valid_o pulses with correct averages.
REQ-040 Pulse rst_ni low after 2 samples -> all outputs read 0 immediately; the next sample 400 -> vout_o = 100 and primed_o = 0.
